gray_ptr_sync: RTL
==================

// Module: gray_ptr_sync
// PURPOSE
//  Parametrised clock-domain-crossing receiver for a Gray-coded FIFO pointer (successor to fixed-depth ptr syncs).
//  Multi-flop synchroniser of configurable depth, then registered Gray->binary conversion, change strobe,
//  modulo step count (delta) and optional sticky illegal-step detector. Lives in the destination domain of
//  the async FIFO (wr ptr into rd domain for empty calc, rd ptr into wr domain for full calc).
// PARAMETERS
//  ADDR_WIDTH   6  FIFO address bits; pointer width PW = ADDR_WIDTH+1 (extra wrap bit)
//  SYNC_STAGES  2  synchroniser flop count, legal 2..8; elaboration error outside range
//  CHECK_STEP   0  1 = enable gray_err detector (only valid when source clk <= destination clk)
// PORTS
//  clk       in   1   destination-domain clock
//  rst       in   1   asynchronous reset, active-high
//  data_in   in   PW  Gray pointer from source domain (registered there, async to clk)
//  err_clr   in   1   synchronous clear of sticky gray_err
//  gray_out  out  PW  synchronised Gray pointer (last chain stage)
//  bin_out   out  PW  binary of gray_out, registered
//  changed   out  1   1-cycle strobe: bin_out updated to a new value this cycle
//  delta     out  PW  (bin_out - previous bin_out) mod 2^PW, aligned with changed; 0 when changed=0
//  gray_err  out  1   sticky: a sampled step differed from predecessor in >1 bit (CHECK_STEP=1 only)
// BEHAVIOUR
//  Reset: rst=1 clears every flop asynchronously; all outputs 0 while rst=1 and until first post-reset edges.
//  Chain: stage[0]<=data_in, stage[i]<=stage[i-1]; gray_out=stage[SYNC_STAGES-1].
//   Latency data_in->gray_out = SYNC_STAGES edges; no combinational logic on data_in before stage[0].
//  Convert stage (one register, all outputs below update together, latency SYNC_STAGES+1):
//   bin_out <= gray2bin(gray_out); prev_gray <= gray_out.
//   changed <= (gray_out != prev_gray); delta <= changed_next ? gray2bin(gray_out)-bin_out : 0, PW-bit wrap.
//  Wrap: bin 2^PW-1 -> 0 is a normal step: delta=1, changed=1. No saturation anywhere.
//  Multi-step (source advanced >1 between samples): legal when CHECK_STEP=0; delta reports step count.
//  gray_err (CHECK_STEP=1): set on cycle after popcount(gray_out ^ prev_gray) > 1; held until err_clr=1
//   or rst. Same-cycle set condition and err_clr: set wins. CHECK_STEP=0: gray_err tied 0.
//  Reset mid-operation: all state discarded; after release outputs follow data_in again with full latency;
//   first post-reset sample of nonzero data_in produces changed=1, delta=gray2bin(data_in).
//  Each chain flop carries synthesis ASYNC_REG attribute; chain flops have no enable.
// STRUCTURE
//  fifo_pkg: function gray2bin(PW), function popcount, localparam SYNC_STAGES_MIN=2 / MAX=8.
//  Sub-module sync_chain #(WIDTH, STAGES): generic reset-to-0 multi-flop bit-vector synchroniser;
//   gray_ptr_sync instantiates it, then holds convert/strobe/delta/error logic itself.
// TESTING  (ADDR_WIDTH=3 -> PW=4, SYNC_STAGES=3 unless noted)
//  1 Reset: rst=1 with data_in=4'b0110 -> all outputs 0; stay 0 for 3 edges after release, then gray_out=0110.
//  2 Latency: data_in 0000->0001 before edge 1 -> gray_out=0001 after edge 3; bin_out=1, changed=1, delta=1
//    after edge 4; changed=0, delta=0 after edge 5.
//  3 Wrap: walk Gray sequence bin 13,14,15,0 (1011,1001,1000,0000) -> bin_out 13..0, delta=1 each step incl 15->0.
//  4 Multi-step, CHECK_STEP=1: data_in 0000->0011 (bin 2) -> delta=2, changed=1, gray_err=1 next cycle;
//    err_clr=1 one cycle -> gray_err=0; same stimulus with CHECK_STEP=0 -> gray_err stays 0.
//  5 Clear vs set: err_clr=1 in same cycle as new >1-bit step -> gray_err remains 1.
//  6 Mid-op reset + depth sweep: rst pulse while chain holds 0101 -> outputs 0 immediately (no clk edge);
//    repeat scenario 2 for SYNC_STAGES=2 and 8 -> gray_out latency 2 and 8 edges exactly.

Source files
------------

// File: rtl/gray_ptr_sync_pkg.sv
// Shared helpers for Gray-coded FIFO pointer handling: code conversion,
// bit counting and the legal range of synchroniser depths.
package gray_ptr_sync_pkg;

   // Widest pointer the helpers handle; callers zero-extend narrower pointers.
   localparam int GRAY_MAX_W = 32;

   // Allowed synchroniser depth range.
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 8;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   // Zero-extended upper bits contribute nothing, so a narrow pointer converts
   // correctly in the low bits of the result.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   // Number of set bits; six bits are enough to count all 32 positions.
   function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] value);
      logic [5:0] count;
      count = '0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         count = count + {5'b0, value[i]};
      end
      return count;
   endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Bundle between the pointer source side and the destination-domain receiver.
// The master drives the raw Gray pointer and the error clear; the slave
// (the receiver) returns the synchronised and decoded pointer information.
interface gray_ptr_sync_if #(
   parameter int ADDR_WIDTH = 6
);
   import gray_ptr_sync_pkg::*;

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] data_in;
   logic          err_clr;
   logic [PW-1:0] gray_out;
   logic [PW-1:0] bin_out;
   logic          changed;
   logic [PW-1:0] delta;
   logic          gray_err;

   modport master (
      output data_in,
      output err_clr,
      input  gray_out,
      input  bin_out,
      input  changed,
      input  delta,
      input  gray_err
   );

   modport slave (
      input  data_in,
      input  err_clr,
      output gray_out,
      output bin_out,
      output changed,
      output delta,
      output gray_err
   );

endinterface

// File: rtl/sync_chain.sv
// Generic multi-flop bit-vector synchroniser. Every flop resets to zero and
// has no enable, so the chain keeps resolving metastability on every edge.
module sync_chain
   import gray_ptr_sync_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;

   // Refuse to build a chain too short to be safe or pointlessly long.
   if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("sync_chain: STAGES out of the supported range 2..8");
   end

   // One register per stage, each in its own generate scope so placement
   // tools see distinct, individually attributed flops.
   for (gi = 0; gi < STAGES; gi++) begin : g_stage
      (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] flop;

      if (gi == 0) begin : g_first
         // First stage samples the asynchronous input directly, no logic in front.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               flop <= '0;
            end else begin
               flop <= d;
            end
         end
      end else begin : g_next
         // Later stages shift the previous stage along the chain.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               flop <= '0;
            end else begin
               flop <= g_stage[gi-1].flop;
            end
         end
      end
   end

   assign q = g_stage[STAGES-1].flop;

endmodule

// File: rtl/gray_ptr_sync.sv
// Destination-domain receiver for a Gray-coded async FIFO pointer:
// synchroniser chain, then one register stage holding the binary pointer,
// a change strobe, the modulo step count and an optional sticky detector
// for steps that changed more than one Gray bit.
module gray_ptr_sync
   import gray_ptr_sync_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int SYNC_STAGES = 2,
   parameter bit CHECK_STEP  = 1'b0
) (
   input logic            clk,
   input logic            rst,
   gray_ptr_sync_if.slave bus
);

   localparam int PW = ADDR_WIDTH + 1;

   // Pointer must fit the package helpers with at least one spare bit.
   if (ADDR_WIDTH < 1 || PW >= GRAY_MAX_W) begin : g_bad_width
      $error("gray_ptr_sync: ADDR_WIDTH out of the supported range");
   end

   logic [PW-1:0]         gray_sync;
   logic [GRAY_MAX_W-1:0] bin_wide;
   logic [PW-1:0]         bin_next;
   logic [PW-1:0]         delta_next;
   logic                  changed_next;
   logic                  step_bad;

   logic [PW-1:0]         prev_gray;
   logic [PW-1:0]         bin_q;
   logic [PW-1:0]         delta_q;
   logic                  changed_q;
   logic                  err_q;
   logic                  unused_bits;

   sync_chain #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_sync_chain (
      .clk (clk),
      .rst (rst),
      .d   (bus.data_in),
      .q   (gray_sync)
   );

   // Decode the synchronised pointer and compare it with the last sample.
   always_comb begin
      bin_wide     = gray2bin(32'(gray_sync));
      bin_next     = bin_wide[PW-1:0];
      changed_next = (gray_sync != prev_gray);
      // Modulo subtraction makes the wrap from all-ones to zero a step of one.
      delta_next   = changed_next ? (bin_next - bin_q) : '0;
      step_bad     = (popcount(32'(gray_sync ^ prev_gray)) > 6'd1);
   end

   // Conversion register: binary pointer, strobe and step count move together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_gray <= '0;
         bin_q     <= '0;
         changed_q <= 1'b0;
         delta_q   <= '0;
      end else begin
         prev_gray <= gray_sync;
         bin_q     <= bin_next;
         changed_q <= changed_next;
         delta_q   <= delta_next;
      end
   end

   if (CHECK_STEP) begin : g_step_check
      // Sticky illegal-step flag; a new bad step beats a simultaneous clear.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            err_q <= 1'b0;
         end else if (step_bad) begin
            err_q <= 1'b1;
         end else if (bus.err_clr) begin
            err_q <= 1'b0;
         end
      end
      assign unused_bits = ^bin_wide[GRAY_MAX_W-1:PW];
   end else begin : g_no_step_check
      // Without the detector the clear input and the step test are ignored.
      assign err_q       = 1'b0;
      assign unused_bits = ^{bin_wide[GRAY_MAX_W-1:PW], bus.err_clr, step_bad};
   end

   assign bus.gray_out = gray_sync;
   assign bus.bin_out  = bin_q;
   assign bus.changed  = changed_q;
   assign bus.delta    = delta_q;
   assign bus.gray_err = err_q;

endmodule
